adc_sample_scheduler: RTL and testbench

Schedules MCP3002 conversions on the `CLKsample` domain and shares the single ADC/SPI engine between two external requesters. It arbitrates round-robin, issues one conversion command per grant, and enforces a CS-high guard interval between frames. It also bounds every frame with a timeout and returns the 8-bit result to the winning requester. It sits between the logger/display consumers and the SPI frame engine.

---
 rtl/adc_sample_scheduler.sv | 181 ++++++++++++++++++
 tb/tb_adc_sample_scheduler.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/adc_sample_scheduler.sv
// Round-robin MCP3002 conversion scheduler: grant, one frame per grant, timeout, CS-high guard.
// Define ADC_AUTOSCAN_EN to add a periodic autoscan participant feeding scan_ch0_o/scan_ch1_o.
module adc_sample_scheduler #(
  parameter int GUARD_CYC = 2,
  parameter int TIMEOUT   = 24,
  parameter int SCAN_DIV  = 256
) (
  input  logic       RESET,
  input  logic       CLKsample,
  input  logic [1:0] req_i,
  input  logic [1:0] req_chan_i,
  output logic [1:0] gnt_o,
  output logic [1:0] rsp_valid_o,
  output logic [7:0] rsp_data_o,
  output logic       rsp_err_o,
  output logic       cmd_start_o,
  output logic       cmd_chan_o,
  input  logic       eng_done_i,
  input  logic [7:0] eng_data_i,
  output logic [7:0] scan_ch0_o,
  output logic [7:0] scan_ch1_o,
  output logic       busy_o
);

`ifdef ADC_AUTOSCAN_EN
  localparam int NPART = 3;
`else
  localparam int NPART = 2;
`endif

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_GUARD} state_t;

  state_t     state_q, state_d;
  logic [5:0] tcnt_q, tcnt_d;
  logic [3:0] gcnt_q, gcnt_d;
  logic [1:0] last_q, last_d, win_q, win_d;
  logic [1:0] gnt_q, gnt_d, rsp_valid_q, rsp_valid_d;
  logic [7:0] rsp_data_q, rsp_data_d;
  logic       rsp_err_q, rsp_err_d, cmd_start_q, cmd_start_d, cmd_chan_q, cmd_chan_d;

  logic [NPART-1:0] pend;
  logic [1:0]       pick;
  logic             pick_ok, pick_chan;

`ifdef ADC_AUTOSCAN_EN
  localparam int DIV_W = $clog2(SCAN_DIV);
  logic [DIV_W-1:0] div_q;
  logic             scan_pend_q, scan_chan_q, div_wrap, scan_grant, scan_done;
  logic [7:0]       scan_ch0_q, scan_ch1_q;

  assign div_wrap   = div_q == DIV_W'(SCAN_DIV - 1);
  assign scan_grant = (state_q == S_IDLE) && pick_ok && (pick == 2'd2);
  assign scan_done  = (state_q == S_WAIT) && eng_done_i && (win_q == 2'd2);
  assign pend       = {scan_pend_q, req_i};
  assign pick_chan  = (pick == 2'd2) ? scan_chan_q : req_chan_i[pick[0]];
  assign scan_ch0_o = scan_ch0_q;
  assign scan_ch1_o = scan_ch1_q;

  // A period elapsing while the scan is still pending just leaves it pending.
  always_ff @(posedge CLKsample or negedge RESET) begin
    if (!RESET) begin
      div_q       <= '0;
      scan_pend_q <= 1'b0;
      scan_chan_q <= 1'b0;
      scan_ch0_q  <= 8'h00;
      scan_ch1_q  <= 8'h00;
    end else begin
      div_q       <= div_wrap ? '0 : div_q + DIV_W'(1);
      scan_pend_q <= div_wrap | (scan_pend_q & ~scan_grant);
      if (scan_grant) scan_chan_q <= ~scan_chan_q;
      if (scan_done) begin
        if (cmd_chan_q) scan_ch1_q <= eng_data_i;
        else            scan_ch0_q <= eng_data_i;
      end
    end
  end
`else
  assign pend       = req_i;
  assign pick_chan  = req_chan_i[pick[0]];
  assign scan_ch0_o = 8'h00;
  assign scan_ch1_o = 8'h00;
`endif

  // Walk downward so the participant nearest after last_q is written last and wins.
  always_comb begin
    int idx;
    idx     = 0;
    pick    = 2'd0;
    pick_ok = 1'b0;
    for (int i = NPART; i >= 1; i--) begin
      idx = (int'(last_q) + i) % NPART;
      if (pend[idx]) begin
        pick    = 2'(idx);
        pick_ok = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    gcnt_d      = gcnt_q;
    last_d      = last_q;
    win_d       = win_q;
    gnt_d       = 2'b00;
    rsp_valid_d = 2'b00;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    cmd_start_d = 1'b0;
    cmd_chan_d  = cmd_chan_q;
    case (state_q)
      S_IDLE: begin
        if (pick_ok) begin
          gnt_d       = (pick == 2'd0) ? 2'b01 : (pick == 2'd1) ? 2'b10 : 2'b00;
          cmd_start_d = 1'b1;
          cmd_chan_d  = pick_chan;
          win_d       = pick;
          last_d      = pick;
          tcnt_d      = '0;
          state_d     = S_WAIT;
        end
      end
      S_WAIT: begin
        // Done has priority over a coincident timeout expiry.
        if (eng_done_i || tcnt_q == 6'(TIMEOUT)) begin
          if (win_q != 2'd2) begin
            rsp_valid_d = (win_q == 2'd0) ? 2'b01 : 2'b10;
            rsp_data_d  = eng_done_i ? eng_data_i : 8'h00;
            rsp_err_d   = ~eng_done_i;
          end
          gcnt_d  = '0;
          state_d = S_GUARD;
        end else begin
          tcnt_d = tcnt_q + 6'd1;
        end
      end
      S_GUARD: begin
        if (gcnt_q == 4'(GUARD_CYC - 1)) state_d = S_IDLE;
        else                             gcnt_d  = gcnt_q + 4'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLKsample or negedge RESET) begin
    if (!RESET) begin
      state_q     <= S_IDLE;
      tcnt_q      <= '0;
      gcnt_q      <= '0;
      last_q      <= 2'(NPART - 1);
      win_q       <= 2'd0;
      gnt_q       <= 2'b00;
      rsp_valid_q <= 2'b00;
      rsp_data_q  <= 8'h00;
      rsp_err_q   <= 1'b0;
      cmd_start_q <= 1'b0;
      cmd_chan_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
      gcnt_q      <= gcnt_d;
      last_q      <= last_d;
      win_q       <= win_d;
      gnt_q       <= gnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      cmd_start_q <= cmd_start_d;
      cmd_chan_q  <= cmd_chan_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign cmd_start_o = cmd_start_q;
  assign cmd_chan_o  = cmd_chan_q;
  assign busy_o      = state_q != S_IDLE;

endmodule

// File: tb/tb_adc_sample_scheduler.sv
// Bench for adc_sample_scheduler (default build): vector table, corner sequences, random traffic
// against a timestamp-level model of grants, responses and guard spacing.
module tb_adc_sample_scheduler;
  localparam int GUARD = 2;
  localparam int TMO   = 24;

  logic       CLKsample = 1'b0, RESET = 1'b0;
  logic [1:0] req = '0, req_chan = '0;
  logic       eng_done = 1'b0;
  logic [7:0] eng_data = '0;
  logic [1:0] gnt, rsp_valid;
  logic [7:0] rsp_data, scan_ch0, scan_ch1;
  logic       rsp_err, cmd_start, cmd_chan, busy;

  int checks = 0, errors = 0;

  adc_sample_scheduler #(.GUARD_CYC(GUARD), .TIMEOUT(TMO), .SCAN_DIV(256)) dut (
    .RESET(RESET), .CLKsample(CLKsample), .req_i(req), .req_chan_i(req_chan),
    .gnt_o(gnt), .rsp_valid_o(rsp_valid), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .cmd_start_o(cmd_start), .cmd_chan_o(cmd_chan), .eng_done_i(eng_done),
    .eng_data_i(eng_data), .scan_ch0_o(scan_ch0), .scan_ch1_o(scan_ch1), .busy_o(busy));

  always #5 CLKsample = ~CLKsample;

  typedef struct {
    logic [1:0] req;
    logic [1:0] chan;
    int         lat;
    logic [7:0] data;
    logic [1:0] e_gnt;
    logic       e_chan;
    logic       e_err;
    logic [7:0] e_data;
    int         e_rsp;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLKsample);
    #1;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, ".gnt"}, gnt, 0);
    chk({tag, ".rsp_valid"}, rsp_valid, 0);
    chk({tag, ".rsp_data"}, rsp_data, 0);
    chk({tag, ".rsp_err"}, rsp_err, 0);
    chk({tag, ".cmd_start"}, cmd_start, 0);
    chk({tag, ".cmd_chan"}, cmd_chan, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".scan_ch0"}, scan_ch0, 0);
    chk({tag, ".scan_ch1"}, scan_ch1, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tv[6];
    // Round-robin pointer starts at 1, so the sequence of winners below is 0,1,0,1,0,1.
    tv[0] = '{2'b01, 2'b01, 16,      8'hA5, 2'b01, 1'b1, 1'b0, 8'hA5, 16};
    tv[1] = '{2'b11, 2'b01, 5,       8'h3C, 2'b10, 1'b0, 1'b0, 8'h3C, 5};
    tv[2] = '{2'b11, 2'b11, 1,       8'hFF, 2'b01, 1'b1, 1'b0, 8'hFF, 1};
    tv[3] = '{2'b10, 2'b10, TMO + 1, 8'h5A, 2'b10, 1'b1, 1'b0, 8'h5A, TMO + 1};
    tv[4] = '{2'b01, 2'b00, TMO + 2, 8'h77, 2'b01, 1'b0, 1'b1, 8'h00, TMO + 1};
    tv[5] = '{2'b10, 2'b00, TMO,     8'h81, 2'b10, 1'b0, 1'b0, 8'h81, TMO};

    repeat (3) tick();
    chk_all_zero("reset");
    RESET = 1'b1;
    tick();

    // ---------------- vector table ----------------
    for (int v = 0; v < 6; v++) begin
      req = tv[v].req; req_chan = tv[v].chan;
      tick();
      chk($sformatf("v%0d.gnt", v), gnt, tv[v].e_gnt);
      chk($sformatf("v%0d.cmd_start", v), cmd_start, 1);
      chk($sformatf("v%0d.cmd_chan", v), cmd_chan, tv[v].e_chan);
      chk($sformatf("v%0d.busy", v), busy, 1);
      for (int k = 1; k <= tv[v].e_rsp + GUARD; k++) begin
        eng_done = (k == tv[v].lat);
        eng_data = eng_done ? tv[v].data : 8'($urandom);
        tick();
        eng_done = 1'b0;
        chk($sformatf("v%0d.rsp_valid@%0d", v, k), rsp_valid, (k == tv[v].e_rsp) ? tv[v].e_gnt : 2'b00);
        chk($sformatf("v%0d.cmd_start@%0d", v, k), cmd_start, 0);
        if (k <= tv[v].e_rsp) chk($sformatf("v%0d.cmd_chan@%0d", v, k), cmd_chan, tv[v].e_chan);
        if (k == tv[v].e_rsp) begin
          chk($sformatf("v%0d.rsp_data", v), rsp_data, tv[v].e_data);
          chk($sformatf("v%0d.rsp_err", v), rsp_err, tv[v].e_err);
          req = 2'b00;
        end
        if (k > tv[v].e_rsp && k < tv[v].e_rsp + GUARD) chk($sformatf("v%0d.busy_guard", v), busy, 1);
      end
      chk($sformatf("v%0d.busy_end", v), busy, 0);
    end

    // ---------------- contention: order 0,1,0 and spacing 16+GUARD+1 ----------------
    begin
      int gcyc[$];
      logic [1:0] gw[$];
      int done_at = -1, n = 0, nrsp = 0;
      req = 2'b11; req_chan = 2'b10;
      while (nrsp < 3 && n < 200) begin
        eng_done = (n == done_at);
        eng_data = 8'(8'h40 + n);
        tick();
        eng_done = 1'b0;
        if (cmd_start) begin gcyc.push_back(n); gw.push_back(gnt); done_at = n + 16; end
        if (rsp_valid != 2'b00) begin nrsp++; if (nrsp == 3) req = 2'b00; end
        n++;
      end
      chk("cont.finished", n < 200, 1);
      chk("cont.ngrants", gw.size(), 3);
      if (gw.size() == 3) begin
        chk("cont.order0", gw[0], 2'b01);
        chk("cont.order1", gw[1], 2'b10);
        chk("cont.order2", gw[2], 2'b01);
        chk("cont.space01", gcyc[1] - gcyc[0], 16 + GUARD + 1);
        chk("cont.space12", gcyc[2] - gcyc[1], 16 + GUARD + 1);
      end
      for (int k = 0; k < 6; k++) begin
        tick();
        chk("cont.withdrawn_no_start", cmd_start, 0);
      end
      chk("cont.busy_end", busy, 0);
    end

    // ---------------- requester 1 drops req right after grant ----------------
    req = 2'b10; req_chan = 2'b10;
    tick();
    chk("wd.gnt", gnt, 2'b10);
    req = 2'b00;
    for (int k = 1; k <= 8; k++) begin
      eng_done = (k == 3); eng_data = 8'hC3;
      tick();
      eng_done = 1'b0;
      chk($sformatf("wd.rsp_valid@%0d", k), rsp_valid, (k == 3) ? 2'b10 : 2'b00);
      if (k == 3) chk("wd.rsp_data", rsp_data, 8'hC3);
      if (k > 1) chk($sformatf("wd.cmd_start@%0d", k), cmd_start, 0);
    end

    // ---------------- reset in the middle of WAIT ----------------
    req = 2'b01; req_chan = 2'b01;
    tick();
    chk("rst.gnt", gnt, 2'b01);
    repeat (8) tick();
    chk("rst.busy_before", busy, 1);
    #2 RESET = 1'b0;
    #1 chk_all_zero("rst.async");
    req = 2'b00;
    repeat (2) tick();
    RESET = 1'b1;
    for (int k = 0; k < 30; k++) begin
      eng_done = ($urandom_range(3) == 0); eng_data = 8'($urandom);
      tick();
      eng_done = 1'b0;
      chk("rst.no_start", cmd_start, 0);
      chk("rst.no_rsp", rsp_valid, 0);
    end

    // ---------------- random traffic vs timestamp model ----------------
    begin
      int g_edge = -100, rsp_edge = -100, ready = 0, done_edge = -100, last = 1, w = 0, lat;
      logic [7:0] d_data = '0, exp_data = '0;
      logic exp_err = 1'b0, exp_chan = 1'b0, e_start;
      logic [1:0] e_gnt;
      for (int n = 0; n < 2000; n++) begin
        for (int i = 0; i < 2; i++)
          if (!req[i] && $urandom_range(3) == 0) begin
            req[i] = 1'b1; req_chan[i] = 1'($urandom_range(1));
          end
        if (n == done_edge) begin
          eng_done = 1'b1; eng_data = d_data;
        end else if (!(n > g_edge && n <= rsp_edge) && $urandom_range(19) == 0) begin
          eng_done = 1'b1; eng_data = 8'($urandom);
        end else begin
          eng_done = 1'b0;
        end
        e_gnt = 2'b00; e_start = 1'b0;
        if (n >= ready && req != 2'b00) begin
          w = (last == 1) ? (req[0] ? 0 : 1) : (req[1] ? 1 : 0);
          e_gnt = (w == 0) ? 2'b01 : 2'b10;
          e_start = 1'b1;
          exp_chan = req_chan[w];
          lat = $urandom_range(TMO + 3, 1);
          d_data = 8'($urandom);
          done_edge = n + lat;
          exp_err = lat > TMO + 1;
          rsp_edge = n + (exp_err ? TMO + 1 : lat);
          exp_data = exp_err ? 8'h00 : d_data;
          ready = rsp_edge + GUARD + 1;
          g_edge = n;
          last = w;
        end
        tick();
        eng_done = 1'b0;
        chk("rnd.gnt", gnt, e_gnt);
        chk("rnd.cmd_start", cmd_start, e_start);
        chk("rnd.rsp_valid", rsp_valid, (n == rsp_edge) ? ((w == 0) ? 2'b01 : 2'b10) : 2'b00);
        chk("rnd.busy", busy, (n >= g_edge && n <= ready - 2));
        if (n >= g_edge && n <= rsp_edge) chk("rnd.cmd_chan", cmd_chan, exp_chan);
        if (n == rsp_edge) begin
          chk("rnd.rsp_data", rsp_data, exp_data);
          chk("rnd.rsp_err", rsp_err, exp_err);
          req[w] = 1'b0;
        end
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
